ram_fifo_ctrl: RTL and testbench

Single-port-RAM FIFO controller: accepts a valid/ready write stream, stores words in the team's parameterised single-port RAM (`ram`), and returns them in order on a valid/ready read stream. It sits directly upstream of `ram` and drives its `we`/`adr`/`din` port while consuming `dout`. Because the RAM has one port, the block arbitrates each cycle between one write and one read, with round-robin fairness under contention.

---
 rtl/ram_fifo_pkg.sv | 10 +
 rtl/rr_arb2.sv | 28 ++
 rtl/ram_fifo_ctrl.sv | 83 ++++++++
 tb/tb_ram_fifo_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared types and helpers for the single-port-RAM FIFO controller.
package ram_fifo_pkg;

   typedef enum logic {PREF_READ = 1'b0, PREF_WRITE = 1'b1} pref_t;

   function automatic int unsigned fifo_depth(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter for the single RAM port: read vs write.
module rr_arb2
   import ram_fifo_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  logic  req_rd,
   input  logic  req_wr,
   output logic  gnt_rd,
   output logic  gnt_wr,
   output pref_t pref
);

   always_comb begin
      gnt_wr = en && req_wr && !(req_rd && pref == PREF_READ);
      gnt_rd = en && req_rd && !gnt_wr;
   end

   // Preference only moves when both sides competed for the port.
   always_ff @(posedge clk) begin
      if (rst)
         pref <= PREF_READ;
      else if (req_rd && req_wr)
         pref <= gnt_rd ? PREF_WRITE : PREF_READ;
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a single-port RAM; one RAM access per cycle,
// head word presented from a registered output stage.
module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_adr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(fifo_depth(ADDR_W));

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              read_req, write_req;
   logic              read_grant, write_grant;
   pref_t             pref;

   assign full      = (count == DEPTH);
   assign empty     = (count == '0);
   assign read_req  = !empty && (!out_valid || out_ready);
   assign write_req = in_valid && !full;
   assign in_ready  = !rst && !full && !(read_req && pref == PREF_READ);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (!rst),
      .req_rd (read_req),
      .req_wr (write_req),
      .gnt_rd (read_grant),
      .gnt_wr (write_grant),
      .pref   (pref)
   );

   always_comb begin
      ram_we  = write_grant;
      ram_adr = write_grant ? wr_ptr : rd_ptr;
      ram_din = in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (write_grant) begin
         wr_ptr <= wr_ptr + ADDR_W'(1);
         count  <= count + (ADDR_W+1)'(1);
      end else if (read_grant) begin
         rd_ptr <= rd_ptr + ADDR_W'(1);
         count  <= count - (ADDR_W+1)'(1);
      end
   end

   // RAM read data is combinational, so the head is captured on the grant edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (read_grant) begin
         out_valid <= 1'b1;
         out_data  <= ram_dout;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural single-port RAM.
module tb_ram_fifo_ctrl;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W:0]   count;
   logic              full, empty;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_adr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   int checks = 0;
   int errors = 0;
   int sent, rcv, acc;

   always #5 clk = ~clk;

   assign ram_dout = mem[ram_adr];
   always @(posedge clk) if (ram_we) mem[ram_adr] <= ram_din;

   ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .full(full), .empty(empty),
      .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_od;
      logic [6:0]  e_cnt;
      logic        e_we;
      logic        e_empty;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive both sides each cycle until n_in words are accepted and n_out are
   // consumed; consumed words must be out_base, out_base+1, ...
   task automatic stream(input int n_in, input int n_out, input logic [31:0] in_base,
                         input logic [31:0] out_base, input logic ordy);
      int s = 0, r = 0, cyc = 0;
      while ((s < n_in || r < n_out) && cyc < 2000) begin
         @(negedge clk);
         in_valid  = (s < n_in);
         in_data   = in_base + 32'(s);
         out_ready = ordy && (r < n_out);
         #1;
         if (out_valid && out_ready) begin
            chk("stream order", out_data, out_base + 32'(r));
            r++;
         end
         if (in_valid && in_ready) s++;
         cyc++;
      end
      if (cyc >= 2000) chk("stream timeout", 32'(r), 32'(n_out));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //         rst   iv    data           ordy  ir    ov    out_data       cnt   we    empty
      tbl[0] = '{1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h0,        7'd0, 1'b0, 1'b1};
      tbl[1] = '{1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h0,        7'd0, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 32'h19229210, 1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        7'd1, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h19229210, 7'd0, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h19229210, 7'd0, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h19229210, 7'd0, 1'b0, 1'b1};

      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("vec%0d out_data", i),  out_data,       tbl[i].e_od);
         chk($sformatf("vec%0d count", i),     32'(count),     32'(tbl[i].e_cnt));
         chk($sformatf("vec%0d ram_we", i),    32'(ram_we),    32'(tbl[i].e_we));
         chk($sformatf("vec%0d empty", i),     32'(empty),     32'(tbl[i].e_empty));
      end

      // Fill: 64 in RAM plus 1 in the output register.
      acc = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 32'(acc); out_ready = 1'b0;
         #1;
         if (in_ready) acc++;
      end
      chk("fill accepted", 32'(acc), 32'd65);
      chk("fill full", 32'(full), 32'd1);
      chk("fill in_ready", 32'(in_ready), 32'd0);
      chk("fill count", 32'(count), 32'd64);
      chk("fill out_data", out_data, 32'd0);
      chk("fill out_valid", 32'(out_valid), 32'd1);

      // Drain everything in order.
      stream(0, 65, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("drain empty", 32'(empty), 32'd1);
      chk("drain out_valid", 32'(out_valid), 32'd0);
      chk("drain count", 32'(count), 32'd0);

      // Two 100-word streams force both pointers across 63->0.
      stream(100, 100, 32'h1000, 32'h1000, 1'b1);
      stream(100, 100, 32'h2000, 32'h2000, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("wrap empty", 32'(empty), 32'd1);

      // Contention: fresh reset, build count=10 without contesting the port.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      sent = 0; rcv = 0;
      @(negedge clk); in_valid = 1'b1; in_data = 32'hC00; #1;
      if (in_ready) sent++;
      @(negedge clk); in_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); in_valid = 1'b1; in_data = 32'hC00 + 32'(sent); #1;
         if (in_ready) sent++;
      end
      @(negedge clk); in_valid = 1'b0; #1;
      chk("cont setup count", 32'(count), 32'd10);
      chk("cont setup out_valid", 32'(out_valid), 32'd1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 32'hC00 + 32'(sent); out_ready = 1'b1;
         #1;
         chk($sformatf("cont%0d grant_we", k), 32'(ram_we), 32'(k % 2));
         chk($sformatf("cont%0d count", k), 32'(count), 32'(10 - (k % 2)));
         if (out_valid) begin
            chk("cont order", out_data, 32'hC00 + 32'(rcv));
            rcv++;
         end
         if (in_ready) sent++;
      end
      stream(0, sent - rcv, 32'h0, 32'hC00 + 32'(rcv), 1'b1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("cont total written", 32'(sent), 32'd15);
      chk("cont empty", 32'(empty), 32'd1);
      chk("cont out_valid", 32'(out_valid), 32'd0);

      // Reset mid-stream with count=20.
      acc = 0;
      for (int c = 0; c < 200 && acc < 21; c++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 32'hD00 + 32'(acc); out_ready = 1'b0;
         #1;
         if (in_ready) acc++;
      end
      @(negedge clk); in_valid = 1'b0; #1;
      chk("midrst count before", 32'(count), 32'd20);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      chk("midrst count", 32'(count), 32'd0);
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      stream(1, 1, 32'h11922952, 32'h11922952, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("midrst empty after", 32'(empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
